// File: rtl/mp_add_seq.sv
// mp_add_seq: serial multi-word adder, one 16-bit carry-lookahead slice per clock.
// Optional subtract support is enabled by defining MP_ADD_SEQ_SUB_EN; without it
// the sub port is accepted but has no effect.

// 16-bit carry-lookahead slice: four 4-bit groups with a second lookahead level.
module mp_cla16 (
  input  logic [15:0] x,
  input  logic [15:0] y,
  input  logic        ci,
  output logic [15:0] sum_c,
  output logic        co_c
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] c;
  logic [3:0]  gg;
  logic [3:0]  gp;
  logic [4:0]  gc;

  // Bit generate/propagate, group lookahead, then per-bit carries inside each group.
  always_comb begin
    g  = x & y;
    p  = x ^ y;
    gg = '0;
    gp = '0;
    gc = '0;
    c  = '0;

    for (int j = 0; j < 4; j++) begin
      gg[j] = g[4*j+3]
            | (p[4*j+3] & g[4*j+2])
            | (p[4*j+3] & p[4*j+2] & g[4*j+1])
            | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]);
      gp[j] = p[4*j+3] & p[4*j+2] & p[4*j+1] & p[4*j];
    end

    gc[0] = ci;
    gc[1] = gg[0] | (gp[0] & ci);
    gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & ci);
    gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
          | (gp[2] & gp[1] & gp[0] & ci);
    gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
          | (gp[3] & gp[2] & gp[1] & gg[0])
          | (gp[3] & gp[2] & gp[1] & gp[0] & ci);

    for (int j = 0; j < 4; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
               | (p[4*j+2] & p[4*j+1] & g[4*j])
               | (p[4*j+2] & p[4*j+1] & p[4*j] & gc[j]);
    end

    sum_c = p ^ c;
    co_c  = gc[4];
  end

endmodule

module mp_add_seq #(
  parameter int unsigned WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16*WORDS-1:0]   a,
  input  logic [16*WORDS-1:0]   b,
  input  logic                  cin,
  input  logic                  sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [16*WORDS-1:0]   sum,
  output logic                  cout,
  output logic                  ovf,
  output logic                  busy
);

  localparam int unsigned W  = 16 * WORDS;
  localparam int unsigned CW = (WORDS > 1) ? $clog2(WORDS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                  state;
  state_t                  state_next;

  logic [WORDS-1:0][15:0]  a_q;
  logic [WORDS-1:0][15:0]  b_q;
  logic [WORDS-1:0][15:0]  sum_q;
  logic                    carry_q;
  logic [CW-1:0]           cnt_q;

  logic                    accept_c;
  logic                    last_c;
  logic [W-1:0]            b_eff_c;
  logic                    carry_in_c;
  logic [15:0]             slice_sum;
  logic                    slice_co;

  assign accept_c = in_valid & in_ready;
  assign last_c   = (cnt_q == CW'(WORDS - 1));
  assign sum      = sum_q;

`ifdef MP_ADD_SEQ_SUB_EN
  // Subtract as a + ~b + 1: invert b and fold sub into the initial carry.
  assign b_eff_c    = b ^ {W{sub}};
  assign carry_in_c = cin ^ sub;
`else
  logic unused_sub;
  assign unused_sub = sub;
  assign b_eff_c    = b;
  assign carry_in_c = cin;
`endif

  // Shared add slice, fed with the word selected by the counter.
  mp_cla16 u_slice (
    .x     (a_q[cnt_q]),
    .y     (b_q[cnt_q]),
    .ci    (carry_q),
    .sum_c (slice_sum),
    .co_c  (slice_co)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: accept, WORDS run cycles, then hold until the result is taken.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept_c) begin
          state_next = RUN;
        end
      end
      RUN: begin
        if (last_c) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake and status flags, registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      in_ready  <= (state_next == IDLE);
      out_valid <= (state_next == DONE);
      busy      <= (state_next == RUN);
    end
  end

  // Operand capture on accept, one word per RUN cycle, flags on the top word.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_c) begin
            a_q     <= a;
            b_q     <= b_eff_c;
            carry_q <= carry_in_c;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout    <= 1'b0;
            ovf     <= 1'b0;
          end
        end
        RUN: begin
          sum_q[cnt_q] <= slice_sum;
          carry_q      <= slice_co;
          if (last_c) begin
            cout <= slice_co;
            ovf  <= (a_q[WORDS-1][15] == b_q[WORDS-1][15]) &&
                    (slice_sum[15] != a_q[WORDS-1][15]);
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mp_add_seq.sv
// Self-checking bench for mp_add_seq (WORDS=4) against an arithmetic reference model.
module tb_mp_add_seq;

  localparam int unsigned WORDS = 4;
  localparam int unsigned W     = 16 * WORDS;

  typedef struct packed {
    logic [W-1:0] s;
    logic         co;
    logic         ov;
  } res_t;

  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic [W-1:0] es;
    logic         eco;
    logic         eov;
  } vec_t;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;
  logic         busy;

  int n_checks;
  int n_pass;

  mp_add_seq #(.WORDS(WORDS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: whole-word arithmetic on the effective operands.
  function automatic res_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input logic msub);
    res_t         r;
    logic [W-1:0] be;
    logic         c0;
    logic [W:0]   t;
`ifdef MP_ADD_SEQ_SUB_EN
    be = msub ? ~mb : mb;
    c0 = mcin ^ msub;
`else
    be = mb;
    c0 = mcin;
    if (msub) c0 = mcin;
`endif
    t    = {1'b0, ma} + {1'b0, be} + (W+1)'(c0);
    r.s  = t[W-1:0];
    r.co = t[W];
    r.ov = (ma[W-1] == be[W-1]) && (t[W-1] != ma[W-1]);
    return r;
  endfunction

  function automatic logic [W-1:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  // One transaction: accept, scramble inputs, wait for the result, consume it.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic ocin, input logic osub,
                       output res_t r, output int lat);
    a = oa; b = ob; cin = ocin; sub = osub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = rnd64(); b = rnd64(); cin = 1'($urandom); sub = 1'($urandom);
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = i;
        break;
      end
    end
    r.s = sum; r.co = cout; r.ov = ovf;
    if (lat > 0) begin
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (sum !== '0) $display("FAIL reset_sum got %h want 0", sum); else n_pass++;
    n_checks++; if (cout !== 1'b0) $display("FAIL reset_cout got %b want 0", cout); else n_pass++;
    n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else n_pass++;
  endtask

  task automatic test_directed();
    vec_t v [4];
    res_t r;
    int   lat;
    v[0] = '{64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0};
    v[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0};
    v[2] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
`ifdef MP_ADD_SEQ_SUB_EN
    v[3] = '{64'd5, 64'd7, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0};
`else
    v[3] = '{64'd5, 64'd7, 1'b0, 1'b1, 64'd12, 1'b0, 1'b0};
`endif
    for (int i = 0; i < 4; i++) begin
      do_op(v[i].a, v[i].b, v[i].cin, v[i].sub, r, lat);
      n_checks++; if (lat != 4) $display("FAIL dir%0d_latency got %0d want 4", i, lat); else n_pass++;
      n_checks++; if (r.s !== v[i].es) $display("FAIL dir%0d_sum got %h want %h", i, r.s, v[i].es); else n_pass++;
      n_checks++; if (r.co !== v[i].eco) $display("FAIL dir%0d_cout got %b want %b", i, r.co, v[i].eco); else n_pass++;
      n_checks++; if (r.ov !== v[i].eov) $display("FAIL dir%0d_ovf got %b want %b", i, r.ov, v[i].eov); else n_pass++;
    end
  endtask

  task automatic test_random();
    res_t         r;
    res_t         e;
    int           lat;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic         rc;
    logic         rs;
    for (int i = 0; i < 24; i++) begin
      ra = rnd64(); rb = rnd64(); rc = 1'($urandom); rs = 1'($urandom);
      if (i % 6 == 1) ra = '1;
      if (i % 6 == 2) rb = {1'b0, {(W-1){1'b1}}};
      e = model(ra, rb, rc, rs);
      do_op(ra, rb, rc, rs, r, lat);
      n_checks++; if (lat != 4) $display("FAIL rnd%0d_latency got %0d want 4", i, lat); else n_pass++;
      n_checks++; if (r !== e) $display("FAIL rnd%0d_result got %h/%b/%b want %h/%b/%b", i, r.s, r.co, r.ov, e.s, e.co, e.ov); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    res_t e;
    int   lat;
    e = model(64'h7FFF_0000_1234_8000, 64'h0FFF_0000_0001_8000, 1'b1, 1'b0);
    a = 64'h7FFF_0000_1234_8000; b = 64'h0FFF_0000_0001_8000; cin = 1'b1; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL bp_busy got %b want 1", busy); else n_pass++;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = i; break; end
    end
    n_checks++; if (lat != 4) $display("FAIL bp_latency got %0d want 4", lat); else n_pass++;
    for (int i = 0; i < 3; i++) begin
      in_valid = (i == 1);
      a = rnd64(); b = rnd64();
      @(posedge clk); #1;
      n_checks++; if ({sum, cout, ovf} !== e) $display("FAIL bp_hold%0d got %h/%b/%b want %h/%b/%b", i, sum, cout, ovf, e.s, e.co, e.ov); else n_pass++;
      n_checks++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready%0d got %b want 0", i, in_ready); else n_pass++;
      n_checks++; if (out_valid !== 1'b1) $display("FAIL bp_out_valid%0d got %b want 1", i, out_valid); else n_pass++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL bp_release_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL bp_release_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL bp_release_busy got %b want 0", busy); else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    res_t r;
    int   lat;
    a = 64'h1111_2222_3333_4444; b = 64'h0101_0202_0303_0404; cin = 1'b1; sub = 1'b0;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) $display("FAIL rr_busy_run got %b want 1", busy); else n_pass++;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rr_in_ready got %b want 1", in_ready); else n_pass++;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rr_out_valid got %b want 0", out_valid); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rr_busy got %b want 0", busy); else n_pass++;
    n_checks++; if (sum !== '0) $display("FAIL rr_sum got %h want 0", sum); else n_pass++;
    n_checks++; if ({cout, ovf} !== 2'b00) $display("FAIL rr_flags got %b want 00", {cout, ovf}); else n_pass++;
    do_op(64'd1, 64'd1, 1'b0, 1'b0, r, lat);
    n_checks++; if (lat != 4) $display("FAIL rr_latency got %0d want 4", lat); else n_pass++;
    n_checks++; if (r.s !== 64'd2) $display("FAIL rr_sum_after got %h want 2", r.s); else n_pass++;
  endtask

  task automatic test_back_to_back();
    res_t exp_q [$];
    int   acc_cyc [$];
    res_t e;
    logic was_ready;
    int   cyc;
    int   got;
    cyc = 0; got = 0;
    out_ready = 1'b1;
    a = rnd64(); b = rnd64(); cin = 1'($urandom); sub = 1'($urandom);
    in_valid = 1'b1;
    for (int i = 0; i < 60 && got < 3; i++) begin
      was_ready = in_ready;
      @(posedge clk); #1;
      cyc++;
      if (was_ready && in_valid) begin
        exp_q.push_back(model(a, b, cin, sub));
        acc_cyc.push_back(cyc);
        a = rnd64(); b = rnd64(); cin = 1'($urandom); sub = 1'($urandom);
        if (acc_cyc.size() == 3) in_valid = 1'b0;
      end
      if (out_valid) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL b2b_unexpected_result got %h want none", sum);
        end else begin
          e = exp_q.pop_front();
          if ({sum, cout, ovf} !== e) $display("FAIL b2b_result%0d got %h/%b/%b want %h/%b/%b", got, sum, cout, ovf, e.s, e.co, e.ov);
          else n_pass++;
        end
        got++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    n_checks++; if (got != 3) $display("FAIL b2b_count got %0d want 3", got); else n_pass++;
    n_checks++;
    if (acc_cyc.size() != 3) $display("FAIL b2b_accepts got %0d want 3", acc_cyc.size());
    else if (acc_cyc[1] - acc_cyc[0] != 6 || acc_cyc[2] - acc_cyc[1] != 6)
      $display("FAIL b2b_interval got %0d,%0d want 6,6", acc_cyc[1] - acc_cyc[0], acc_cyc[2] - acc_cyc[1]);
    else n_pass++;
  endtask

  initial begin
    n_checks  = 0;
    n_pass    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    cin       = 1'b0;
    sub       = 1'b0;
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
